// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the hex-to-segment table (active-low, bit 6 = a ... bit 0 = g).
package seg7_pkg;

  localparam int SEG_DIGIT = 7;  // segments per digit, excluding dp

  typedef logic [SEG_DIGIT-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t s;
    case (nibble)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Round-robin multiplexed driver for a common-anode 7-segment display with
// frame-synchronous value commit, leading-zero blanking and an anti-ghost gap.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output seg_t                    a_to_g,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic                       blank_lz;
    logic [NUM_DIGITS-1:0]      en;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0][3:0] value;
  } disp_t;

  disp_t live, pend, act;

  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx;
  logic             tick, wrap;

  assign live = {blank_lz, digit_en, dp_in, value};
  assign tick = (pre == PRE_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // Active only changes at the frame boundary so one frame never mixes values;
  // a load coincident with the boundary goes straight through.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre  <= '0;
      idx  <= '0;
      pend <= '0;
      act  <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      if (load) pend <= live;
      if (wrap) act <= load ? live : pend;
    end
  end

  logic [NUM_DIGITS-1:0]               lz_blank;
  logic [NUM_DIGITS-1:0][SEG_DIGIT-1:0] seg_all;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg7_hex_decode u_dec (
      .nibble (act.value[g]),
      .seg    (seg_all[g])
    );
    if (g == 0) begin : g_lsd
      assign lz_blank[g] = 1'b0;
    end else begin : g_hi
      assign lz_blank[g] = act.blank_lz && (act.value[NUM_DIGITS-1:g] == '0);
    end
  end

  logic in_gap;
  if (BLANK_CYCLES > 0) begin : g_gap
    assign in_gap = (pre < PRE_W'(BLANK_CYCLES));
  end else begin : g_nogap
    assign in_gap = 1'b0;
  end

  logic blank;
  assign blank = in_gap || !act.en[idx] || lz_blank[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= '1;
      a_to_g      <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (pre == '0) && (idx == '0);
      if (blank) begin
        an     <= '1;
        a_to_g <= SEG_BLANK;
        dp     <= 1'b1;
      end else begin
        an     <= ~(NUM_DIGITS'(1) << idx);
        a_to_g <= seg_all[idx];
        dp     <= ~act.dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: table of per-slot expectations plus hand sequences.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        blank_lz;
  logic        load;
  logic [7:0]  an;
  logic [6:0]  a_to_g;
  logic        dp;
  logic        frame_start;

  seg7_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .blank_lz    (blank_lz),
    .load        (load),
    .an          (an),
    .a_to_g      (a_to_g),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [7:0]  dpi;
    logic [7:0]  en;
    logic        blz;
  } cfg_t;

  typedef struct {
    int         c;
    int         k;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  cfg_t cfgs[7];
  vec_t tv[$];

  logic [7:0] an_s[32];
  logic [6:0] seg_s[32];
  logic       dp_s[32];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input int c, input int k, input logic [7:0] a, input logic [6:0] s, input logic d);
    vec_t x;
    x.c = c; x.k = k; x.an = a; x.seg = s; x.dp = d;
    tv.push_back(x);
  endtask

  task automatic wait_fs();
    bit found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (frame_start) found = 1;
    end
    if (!found) begin
      nvec++;
      nerr++;
      $display("FAIL frame_start timeout: got none expected pulse");
    end
  endtask

  task automatic do_load(input cfg_t c);
    @(negedge clk);
    value = c.v; dp_in = c.dpi; digit_en = c.en; blank_lz = c.blz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Skip one frame so the captured one is certainly after the commit.
  task automatic capture();
    wait_fs();
    wait_fs();
    an_s[0] = an; seg_s[0] = a_to_g; dp_s[0] = dp;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      an_s[k] = an; seg_s[k] = a_to_g; dp_s[k] = dp;
    end
  endtask

  initial begin
    int cur;
    cfgs[0] = '{32'h0000_00A5, 8'h00, 8'hFF, 1'b0};
    cfgs[1] = '{32'h0000_00A5, 8'h00, 8'hFF, 1'b1};
    cfgs[2] = '{32'h0000_0000, 8'h00, 8'hFF, 1'b1};
    cfgs[3] = '{32'h0000_00A5, 8'h04, 8'hF0, 1'b0};
    cfgs[4] = '{32'h7654_3210, 8'h04, 8'hFF, 1'b0};
    cfgs[5] = '{32'hFEDC_BA98, 8'h00, 8'hFF, 1'b1};
    cfgs[6] = '{32'h0010_0000, 8'h00, 8'hFF, 1'b1};

    add(0,  0, 8'hFF, 7'b1111111, 1'b1);
    add(0,  1, 8'hFE, 7'b0100100, 1'b1);
    add(0,  5, 8'hFD, 7'b0001000, 1'b1);
    add(0,  9, 8'hFB, 7'b0000001, 1'b1);
    add(0, 28, 8'hFF, 7'b1111111, 1'b1);
    add(0, 31, 8'h7F, 7'b0000001, 1'b1);
    add(1,  2, 8'hFE, 7'b0100100, 1'b1);
    add(1,  4, 8'hFF, 7'b1111111, 1'b1);
    add(1,  6, 8'hFD, 7'b0001000, 1'b1);
    add(1, 10, 8'hFF, 7'b1111111, 1'b1);
    add(1, 30, 8'hFF, 7'b1111111, 1'b1);
    add(2,  1, 8'hFE, 7'b0000001, 1'b1);
    add(2,  5, 8'hFF, 7'b1111111, 1'b1);
    add(2, 29, 8'hFF, 7'b1111111, 1'b1);
    add(3,  1, 8'hFF, 7'b1111111, 1'b1);
    add(3,  9, 8'hFF, 7'b1111111, 1'b1);
    add(3, 17, 8'hEF, 7'b0000001, 1'b1);
    add(3, 29, 8'h7F, 7'b0000001, 1'b1);
    add(4,  9, 8'hFB, 7'b0010010, 1'b0);
    add(4, 13, 8'hF7, 7'b0000110, 1'b1);
    add(4, 17, 8'hEF, 7'b1001100, 1'b1);
    add(4, 25, 8'hBF, 7'b0100000, 1'b1);
    add(4, 29, 8'h7F, 7'b0001111, 1'b1);
    add(5,  1, 8'hFE, 7'b0000000, 1'b1);
    add(5,  5, 8'hFD, 7'b0000100, 1'b1);
    add(5,  9, 8'hFB, 7'b0001000, 1'b1);
    add(5, 13, 8'hF7, 7'b1100000, 1'b1);
    add(5, 17, 8'hEF, 7'b0110001, 1'b1);
    add(5, 21, 8'hDF, 7'b1000010, 1'b1);
    add(5, 25, 8'hBF, 7'b0110000, 1'b1);
    add(5, 29, 8'h7F, 7'b0111000, 1'b1);
    add(6,  5, 8'hFD, 7'b0000001, 1'b1);
    add(6, 21, 8'hDF, 7'b1001111, 1'b1);
    add(6, 25, 8'hFF, 7'b1111111, 1'b1);
    add(6, 29, 8'hFF, 7'b1111111, 1'b1);

    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; digit_en = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {an, a_to_g, dp}, {8'hFF, 7'h7F, 1'b1});
    chk("reset frame_start", {15'd0, frame_start}, 16'd0);
    reset = 1'b0;

    cur = -1;
    foreach (tv[i]) begin
      if (tv[i].c != cur) begin
        do_load(cfgs[tv[i].c]);
        capture();
        cur = tv[i].c;
      end
      chk($sformatf("vec%0d cfg%0d k%0d {an,seg,dp}", i, tv[i].c, tv[i].k),
          {an_s[tv[i].k], seg_s[tv[i].k], dp_s[tv[i].k]},
          {tv[i].an, tv[i].seg, tv[i].dp});
    end

    // Mid-frame load must not disturb the frame in progress.
    do_load(cfgs[0]);
    capture();
    wait_fs();
    repeat (10) @(negedge clk);
    value = 32'h1111_1111; dp_in = 8'h00; digit_en = 8'hFF; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    chk("midload old d3", {an, a_to_g, dp}, {8'hF7, 7'b0000001, 1'b1});
    repeat (12) @(negedge clk);
    chk("midload old d6", {an, a_to_g, dp}, {8'hBF, 7'b0000001, 1'b1});
    wait_fs();
    @(negedge clk);
    chk("midload new d0", {an, a_to_g, dp}, {8'hFE, 7'b1001111, 1'b1});

    // Load sampled on the wrap edge shows in the very next frame.
    wait_fs();
    repeat (30) @(negedge clk);
    value = 32'h2222_2222; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("wrapload old d7", {an, a_to_g, dp}, {8'h7F, 7'b1001111, 1'b1});
    @(negedge clk);
    chk("wrapload frame_start", {15'd0, frame_start}, 16'd1);
    @(negedge clk);
    chk("wrapload new d0", {an, a_to_g, dp}, {8'hFE, 7'b0010010, 1'b1});

    // Reset in slot 5 drops everything, including pending.
    wait_fs();
    repeat (21) @(negedge clk);
    chk("pre-reset d5", {an, a_to_g, dp}, {8'hDF, 7'b0010010, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    chk("midreset outputs", {an, a_to_g, dp}, {8'hFF, 7'h7F, 1'b1});
    chk("midreset frame_start", {15'd0, frame_start}, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("restart frame_start", {15'd0, frame_start}, 16'd1);
    capture();
    chk("post-reset d0 dark", {an_s[1], seg_s[1], dp_s[1]}, {8'hFF, 7'h7F, 1'b1});
    chk("post-reset d5 dark", {an_s[22], seg_s[22], dp_s[22]}, {8'hFF, 7'h7F, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
